// File: rtl/calc_pkg.sv
// calc_pkg: calculator number format and display character codes
package calc_pkg;
  localparam int NumDigits = 8;
  localparam int ExpWidth = 5;
  localparam int IdxWidth = $clog2(NumDigits) + 1;
  typedef struct packed {
    logic                      error;
    logic                      sign;
    logic [ExpWidth-1:0]       exponent;
    logic [NumDigits-1:0][3:0] significand;
  } num_t;
  localparam logic [7:0] CharMinus = 8'h2D;
  localparam logic [7:0] CharPoint = 8'h2E;
  localparam logic [7:0] CharError = 8'h45;
  localparam logic [7:0] CharZero  = 8'h30;
endpackage

// File: rtl/num_trim_len.sv
// num_trim_len: index of the lowest nonzero digit, NumDigits when all digits are zero
`ifdef NUM_SERIALIZER_TRIM_EN
module num_trim_len
  import calc_pkg::*;
(
  input  logic [NumDigits-1:0][3:0] significand,
  output logic [IdxWidth-1:0]       lo
);
  always_comb begin
    lo = IdxWidth'(NumDigits);
    for (int i = NumDigits - 1; i >= 0; i--) lo = (significand[i] != 4'd0) ? IdxWidth'(i) : lo;
  end
endmodule
`endif

// File: rtl/num_serializer.sv
// num_serializer: prints one calc_pkg::num_t as ASCII characters over valid/ready.
// NUM_SERIALIZER_TRIM_EN suppresses trailing zero fraction digits (and a bare point).
module num_serializer
  import calc_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [$bits(num_t)-1:0]  num_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [7:0]               char_o,
  output logic                     char_valid_o,
  input  logic                     char_ready_i,
  output logic                     char_last_o
);
  localparam logic [2:0] Idle = 3'd0, Sign = 3'd1, Lead0 = 3'd2, Int = 3'd3,
                         Point = 3'd4, Frac = 3'd5, Err = 3'd6;
  logic [2:0] state, state_n;
  logic [IdxWidth-1:0] idx, idx_n, lo, int_end, frac_top;
  num_t r, in;
  logic has_frac, hs_in, hs_out, last;
  assign in = num_t'(num_i);
  assign in_ready_o = (state == Idle) && !rst_i;
  assign hs_in = in_valid_i && in_ready_o;
  assign hs_out = char_valid_o && char_ready_i;
`ifdef NUM_SERIALIZER_TRIM_EN
  num_trim_len u_trim (.significand(r.significand), .lo(lo));
`else
  assign lo = '0;
`endif
  // int_end is the last integer digit index; the fraction starts just below it
  assign int_end = IdxWidth'(NumDigits - int'(r.exponent));
  assign frac_top = int_end - 1'b1;
  assign has_frac = (int'(r.exponent) < NumDigits) && (lo <= frac_top);
  assign last = (state == Err) || (state == Lead0 && !has_frac) ||
                (state == Int && idx == int_end && !has_frac) || (state == Frac && idx == lo);
  assign char_valid_o = state != Idle;
  assign char_last_o = last;
  assign char_o = state == Sign  ? CharMinus :
                  state == Lead0 ? CharZero  :
                  state == Point ? CharPoint :
                  state == Err   ? CharError :
                  (state == Int || state == Frac) ? CharZero + {4'd0, r.significand[idx[IdxWidth-2:0]]} :
                  8'h00;
  // Next state always names a state that emits a character, so no bubbles
  always_comb begin
    state_n = state;
    idx_n = idx;
    if (hs_in) begin
      state_n = (in.error || int'(in.exponent) > NumDigits) ? Err :
                (in.sign && in.significand != '0) ? Sign :
                (in.exponent == '0) ? Lead0 : Int;
      idx_n = IdxWidth'(NumDigits - 1);
    end else if (hs_out) begin
      if (last) state_n = Idle;
      else begin
        case (state)
          Sign: begin
            state_n = (r.exponent == '0) ? Lead0 : Int;
            idx_n = IdxWidth'(NumDigits - 1);
          end
          Lead0: state_n = Point;
          Int: begin
            state_n = (idx == int_end) ? Point : Int;
            idx_n = (idx == int_end) ? idx : idx - 1'b1;
          end
          Point: begin
            state_n = Frac;
            idx_n = frac_top;
          end
          Frac: idx_n = idx - 1'b1;
          default: state_n = Idle;
        endcase
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= Idle;
      idx <= '0;
      r <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      if (hs_in) r <= in;
    end
  end
endmodule

// File: tb/tb_num_serializer.sv
// tb_num_serializer: randomized bench checking characters against a string-level model
module tb_num_serializer;
  import calc_pkg::*;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, char_ready = 1'b1;
  num_t num_in = '0;
  logic in_ready, char_valid, char_last;
  logic [7:0] char_o;
  int vectors = 0, miscompares = 0, hs_count = 0, pos = 0, ready_mode = 0;
  bit active = 1'b0;
  string exp_s = "";

  always #5 clk = ~clk;

  num_serializer dut (
    .clk_i(clk), .rst_i(rst), .num_i(num_in), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .char_o(char_o), .char_valid_o(char_valid), .char_ready_i(char_ready), .char_last_o(char_last)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  function automatic void chk_str(string name, string act, string req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, req);
    end
  endfunction

  // Printed form of a number, built as text from the display rules
  function automatic string model(num_t n);
    string s = "";
    int e = int'(n.exponent);
    bit has_pt = 1'b0;
    if (n.error || e > NumDigits) return "E";
    if (n.sign && n.significand != '0) s = "-";
    if (e == 0) s = {s, "0."};
    for (int i = NumDigits - 1; i >= 0; i--) begin
      if (e > 0 && e < NumDigits && i == NumDigits - e - 1) s = {s, "."};
      s = $sformatf("%s%c", s, 8'h30 + {4'd0, n.significand[i]});
    end
`ifdef NUM_SERIALIZER_TRIM_EN
    for (int i = 0; i < s.len(); i++) if (s[i] == 8'h2E) has_pt = 1'b1;
    if (has_pt) begin
      while (s.len() > 0 && s[s.len()-1] == 8'h30) s = s.substr(0, s.len() - 2);
      if (s.len() > 0 && s[s.len()-1] == 8'h2E) s = s.substr(0, s.len() - 2);
    end
`endif
    return s;
  endfunction

  function automatic num_t mk(bit e, bit s, int ex, logic [31:0] d);
    num_t n;
    n.error = e;
    n.sign = s;
    n.exponent = ExpWidth'(ex);
    n.significand = d;
    return n;
  endfunction

  function automatic num_t rnd_num();
    num_t n;
    n.error = ($urandom_range(0, 11) == 0);
    n.sign = 1'($urandom);
    n.exponent = ExpWidth'($urandom_range(0, 11));
    for (int i = 0; i < NumDigits; i++)
      n.significand[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
    if ($urandom_range(0, 9) == 0) n.significand = '0;
    return n;
  endfunction

  // Single compare process: every cycle the outputs are checked against the model text
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", {31'd0, char_valid}, 32'd0);
      chk("rst_last", {31'd0, char_last}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_char", {24'd0, char_o}, 32'd0);
      active = 1'b0;
    end else if (active) begin
      chk("valid", {31'd0, char_valid}, 32'd1);
      chk("char", {24'd0, char_o}, {24'd0, exp_s[pos]});
      chk("last", {31'd0, char_last}, {31'd0, pos == exp_s.len() - 1});
      chk("busy_ready", {31'd0, in_ready}, 32'd0);
      if (char_valid && char_ready) begin
        hs_count++;
        pos++;
        if (pos >= exp_s.len()) active = 1'b0;
      end
    end else begin
      chk("idle_valid", {31'd0, char_valid}, 32'd0);
      chk("idle_ready", {31'd0, in_ready}, 32'd1);
      if (in_valid && in_ready) begin
        exp_s = model(num_in);
        pos = 0;
        active = 1'b1;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    char_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ~char_ready : 1'($urandom_range(0, 3) != 0);
  end

  task automatic send(input num_t n);
    int t = 0;
    @(posedge clk);
    #1;
    num_in = n;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      miscompares++;
      $display("FAIL accept_timeout: in_ready stayed 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    num_in.significand = $urandom;
  endtask

  task automatic wait_done();
    int t = 0;
    while (active && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (active) begin
      miscompares++;
      $display("FAIL done_timeout: sequence still active expected finished");
    end
  endtask

  num_t s1, s2, s3, s3b, s4, s5;
  initial begin
    int base, t;
    s1 = mk(0, 0, 3, 32'h12345000);
    s2 = mk(0, 1, 0, 32'h50000000);
    s3 = mk(1, 0, 4, 32'h87654321);
    s3b = mk(0, 0, 9, 32'h12345678);
    s4 = mk(0, 0, 8, 32'h99999999);
    s5 = mk(0, 1, 0, 32'h00000000);
`ifdef NUM_SERIALIZER_TRIM_EN
    chk_str("pin_s1", model(s1), "123.45");
    chk_str("pin_s2", model(s2), "-0.5");
    chk_str("pin_s5", model(s5), "0");
`else
    chk_str("pin_s1", model(s1), "123.45000");
    chk_str("pin_s2", model(s2), "-0.50000000");
    chk_str("pin_s5", model(s5), "0.00000000");
`endif
    chk_str("pin_s3", model(s3), "E");
    chk_str("pin_s3b", model(s3b), "E");
    chk_str("pin_s4", model(s4), "99999999");
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    send(s1); wait_done();
    send(s2); wait_done();
    send(s3); wait_done();
    send(s3b); wait_done();
    base = hs_count;
    ready_mode = 1;
    send(s4); wait_done();
    chk("s4_handshakes", hs_count - base, 32'd8);
    ready_mode = 0;
    send(s5); wait_done();
    base = hs_count;
    t = 0;
    send(s1);
    while (hs_count < base + 3 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    rst = 1'b1;
    #1;
    chk("s6_rst_valid", {31'd0, char_valid}, 32'd0);
    chk("s6_rst_last", {31'd0, char_last}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    send(s2); wait_done();
    for (int k = 0; k < 300; k++) begin
      ready_mode = $urandom_range(0, 2);
      send(rnd_num());
      wait_done();
    end
    ready_mode = 0;
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/num_serializer.md
# num_serializer

Streams one calculator result as display characters. Accepts a `calc_pkg::num_t` on a valid/ready input and emits it one ASCII character per handshake on a valid/ready output, with `char_last_o` marking the final character. It sits downstream of the ALU (`alu_add` and siblings) and consumes their `result_o`/`out_valid_o`/`out_ready_i` port. It feeds the display/UART path.

## Interface
- No parameters; digit count is `calc_pkg::NumDigits` (N).
- Reset is asynchronous and active-high; the clock is `clk_i` and the reset is `rst_i`.
- `clk_i` input 1: clock; all state changes on posedge.
- `rst_i` input 1: asynchronous, active-high reset.
- `num_i` input `$bits(calc_pkg::num_t)`: number to print.
- `in_valid_i` input 1: `num_i` valid.
- `in_ready_o` output 1: block can accept a number.
- `char_o` output 8: ASCII character.
- `char_valid_o` output 1: `char_o` valid.
- `char_ready_i` input 1: sink accepts the character.
- `char_last_o` output 1: `char_o` is the final character of the number.

## Operation
- **Number format.** The value is 0.d[N-1]d[N-2]…d[0] × 10^exponent.
  - `significand[N-1]` is the most significant digit (MSD).
  - Digits are BCD 0–9.
- **Capture.** On an input handshake (`in_valid_i && in_ready_o`), `num_i` is registered internally. The output sequence is fixed from the captured copy only.
- **Character sequence**, in order:
  - `error==1`, or exponent > N: the single character "E".
  - `sign==1` and significand ≠ 0: "-". Negative zero prints no sign.
  - `exponent==0`: "0" then ".", then d[N-1]…d[0].
  - `1 ≤ exponent < N`: d[N-1]…d[N-exponent], then ".", then d[N-exponent-1]…d[0].
  - `exponent==N`: all N digits, no ".".
- **Digit encoding.** Digits are emitted as 8'h30+d. "-" is 8'h2D, "." is 8'h2E, "E" is 8'h45.
- **FSM states.**
  - IDLE: `in_ready_o=1` → SIGN.
  - SIGN → LEAD0 / INT / ERR.
  - LEAD0 ("0") → POINT.
  - INT: index counts down per handshake → POINT / FRAC_DONE.
  - POINT → FRAC.
  - FRAC: index counts down.
  - ERR.
  - The final handshake returns the FSM to IDLE.
- **Skipped states.** States that emit nothing are skipped combinationally when computing the next state, so no bubble cycles occur. Example: SIGN with a positive number goes directly to emitting the first digit.
- **Digit index.** The index counter is `$clog2(N)+1` bits and never wraps. Exponent 0 and exponent N are terminal cases, not wrap cases.

## Timing
- **Reset values** (async, take effect immediately): state IDLE, `char_valid_o=0`, `char_last_o=0`, `char_o=8'h00`. `in_ready_o=0` while `rst_i` is high.
- **Input acceptance.** `in_ready_o = (state==IDLE) && !rst_i`. Exactly one number is accepted per sequence.
- **Latency.** Input handshake at cycle t → first `char_valid_o` at t+1.
- **Throughput.** One character per cycle while `char_ready_i=1`.
- **Output handshake rules.**
  - While `char_valid_o && !char_ready_i`: `char_o` and `char_last_o` hold stable.
  - `char_valid_o` never drops without a handshake, except on reset.
- **Turnaround.** Handshake on `char_last_o` at cycle t → `in_ready_o=1` at t+1, i.e. one idle cycle between numbers.
- **Reset mid-sequence.** Remaining characters are discarded, with no partial `char_last_o`.
- `num_i` changes while `in_ready_o=0` are ignored.

## Configuration
- Macro: `NUM_SERIALIZER_TRIM_EN`.
- **Defined:** trailing zero fraction digits are suppressed. If no fraction digits remain, "." is also suppressed. `char_last_o` moves to the last emitted character. Zero prints as "0".
- **Undefined:** all N digits are always printed as described in Operation. No trim logic is present.

## Structure
- **`calc_pkg`:** add localparams `CharMinus`, `CharPoint`, `CharError`, `CharZero`.
- **In-module:** the FSM state enum is local to this block.
- **Sub-module `num_trim_len`:** compiled only under `NUM_SERIALIZER_TRIM_EN`. It is combinational. Input is the significand; output is the index of the lowest nonzero digit, or N if all digits are zero. It is evaluated on the registered copy.

## Test plan
Bench uses N=8 and a sink that checks characters against a reference string; expected results are given untrimmed / trimmed.

1. sign=0, exp=3, digits 1,2,3,4,5,0,0,0 (MSD first), `char_ready_i`=1 → "123.45000" in 9 consecutive cycles, last on final "0". Trimmed: "123.45".
2. sign=1, exp=0, digits 5,0,0,0,0,0,0,0 → "-0.50000000". Trimmed: "-0.5".
3. error=1 with arbitrary digits → single "E" with `char_last_o=1`, first char at t+1, `in_ready_o` high at the following cycle. Same result for exp=9.
4. exp=8, all digits 9, `char_ready_i` toggling 1/0 → "99999999" with no ".". `char_o` stable in every stalled cycle; 8 handshakes total.
5. sign=1, all digits 0, exp=0 → "0.00000000" with no "-". Trimmed: "0".
6. Reset after 3 characters of scenario 1 → `char_valid_o=0` immediately. After release, scenario 2 input prints correctly in full.
